gpr_wb: RTL and testbench

Writeback stage that sits directly upstream of the general-purpose register file and drives its write port (`rd`, `di`, `we`). It accepts completed instructions from execute, waits for the memory read response on loads, and byte/half-aligns and extends the loaded data. It then presents a single-cycle, glitch-free write to the register file. It also reports misaligned, illegal or timed-out loads and, optionally, exposes bypass and pending-destination information to decode.

---
 rtl/gpr_wb.sv | 174 +++++++++++++++++
 tb/tb_gpr_wb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb.sv
// Writeback stage driving the GPR file write port; waits for load data, aligns and extends it.
// Optional bypass/pending-destination outputs are built only when GPR_WB_FWD_EN is defined.
module gpr_wb #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_sel,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc4,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        gpr_we,
  output logic [4:0]  gpr_rd,
  output logic [31:0] gpr_di,
  output logic        load_err,
  output logic        busy,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {StIdle = 1'b0, StWait = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        gpr_we_q, gpr_we_d;
  logic [4:0]  gpr_rd_q, gpr_rd_d;
  logic [31:0] gpr_di_q, gpr_di_d;
  logic        load_err_q, load_err_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_bad;

  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_lo_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    ld_bad  = 1'b0;
    case (funct3_q)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010: ld_data = mem_rdata;
      3'b100: ld_data = {24'h0, ld_byte};
      3'b101: ld_data = {16'h0, ld_half};
      default: ld_bad = 1'b1;
    endcase
    // Misaligned halfword or word access.
    if ((funct3_q[1:0] == 2'b01 && addr_lo_q[0]) || (funct3_q == 3'b010 && addr_lo_q != 2'd0)) begin
      ld_bad = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    gpr_we_d   = 1'b0;
    gpr_rd_d   = gpr_rd_q;
    gpr_di_d   = gpr_di_q;
    load_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          unique case (in_sel)
            2'b00: begin
              gpr_rd_d = in_rd;
              gpr_di_d = in_alu;
              gpr_we_d = |in_rd;
            end
            2'b10: begin
              gpr_rd_d = in_rd;
              gpr_di_d = in_pc4;
              gpr_we_d = |in_rd;
            end
            2'b01: begin
              rd_d      = in_rd;
              funct3_d  = in_funct3;
              addr_lo_d = in_addr_lo;
              cnt_d     = 8'd0;
              state_d   = StWait;
            end
            2'b11: ;
          endcase
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the final timeout cycle still completes normally.
        if (mem_rvalid) begin
          state_d = StIdle;
          if (ld_bad) begin
            load_err_d = 1'b1;
          end else begin
            gpr_rd_d = rd_q;
            gpr_di_d = ld_data;
            gpr_we_d = |rd_q;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d    = StIdle;
          load_err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      gpr_we_q   <= 1'b0;
      gpr_rd_q   <= 5'd0;
      gpr_di_q   <= 32'd0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      gpr_we_q   <= gpr_we_d;
      gpr_rd_q   <= gpr_rd_d;
      gpr_di_q   <= gpr_di_d;
      load_err_q <= load_err_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q == StWait);
  assign gpr_we   = gpr_we_q;
  assign gpr_rd   = gpr_rd_q;
  assign gpr_di   = gpr_di_q;
  assign load_err = load_err_q;

`ifdef GPR_WB_FWD_EN
  assign fwd_valid  = gpr_we_q;
  assign fwd_rd     = gpr_rd_q;
  assign fwd_data   = gpr_di_q;
  assign pend_valid = (state_q == StWait) && (rd_q != 5'd0);
  assign pend_rd    = (state_q == StWait) ? rd_q : 5'd0;
`else
  assign fwd_valid  = 1'b0;
  assign fwd_rd     = 5'd0;
  assign fwd_data   = 32'd0;
  assign pend_valid = 1'b0;
  assign pend_rd    = 5'd0;
`endif

endmodule

// File: tb/tb_gpr_wb.sv
// Directed-vector bench for gpr_wb: ALU/PC+4 writes, aligned loads, error and timeout loads,
// async reset mid-load, and bypass/pending outputs (GPR_WB_FWD_EN selects which are expected).
module tb_gpr_wb;

`ifdef GPR_WB_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_sel = 2'b11;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_pc4 = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_di;
  logic        load_err;
  logic        busy;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  int n_vec = 0;
  int n_err = 0;
  int pend_bad;
  int nbusy;

  gpr_wb #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_sel(in_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu(in_alu),
    .in_pc4(in_pc4), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .gpr_we(gpr_we),
    .gpr_rd(gpr_rd), .gpr_di(gpr_di), .load_err(load_err), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, hold WAIT for dly cycles with mem_rvalid in the last one, then stop at
  // the cycle after the response (the write/error cycle).
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input int dly, input logic [31:0] data, output int busy_n);
    in_valid = 1'b1; in_sel = 2'b01; in_rd = rd; in_funct3 = f3; in_addr_lo = lo;
    tick();
    in_valid = 1'b0; in_sel = 2'b11;
    busy_n = 0;
    pend_bad = 0;
    for (int i = 0; i < dly; i++) begin
      if (busy) busy_n++;
      if (pend_valid !== (FwdEn && rd != 5'd0)) pend_bad++;
      if (pend_rd !== (FwdEn ? rd : 5'd0)) pend_bad++;
      if (i == dly - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_we", gpr_we, 0);
    check("rst_rd", gpr_rd, 0);
    check("rst_di", gpr_di, 0);
    check("rst_err", load_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_fwd", {fwd_valid, fwd_rd, pend_valid, pend_rd}, 0);
    check("rst_fwd_data", fwd_data, 0);
    #1 rst_n = 1'b1;
    tick();

    // Back-to-back ALU writes
    in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd5; in_alu = 32'h1234_5678;
    tick();
    check("alu0_we", gpr_we, 1);
    check("alu0_rd", gpr_rd, 5);
    check("alu0_di", gpr_di, 32'h1234_5678);
    check("alu0_ready", in_ready, 1);
    check("alu0_fwd_v", fwd_valid, FwdEn ? 1 : 0);
    check("alu0_fwd_d", fwd_data, FwdEn ? 32'h1234_5678 : 0);
    in_rd = 5'd6; in_alu = 32'hDEAD_BEEF;
    tick();
    check("alu1_we", gpr_we, 1);
    check("alu1_rd", gpr_rd, 6);
    check("alu1_di", gpr_di, 32'hDEAD_BEEF);
    check("alu1_ready", in_ready, 1);
    in_sel = 2'b10; in_rd = 5'd1; in_pc4 = 32'h0000_1004;
    tick();
    check("pc4_we", gpr_we, 1);
    check("pc4_di", gpr_di, 32'h0000_1004);
    in_valid = 1'b0;
    tick();
    check("idle_we", gpr_we, 0);

    // LB, offset 3, 4-cycle response
    do_load(5'd7, 3'b000, 2'd3, 4, 32'h80FF_FFFF, nbusy);
    check("lb_busy_n", nbusy, 4);
    check("lb_we", gpr_we, 1);
    check("lb_rd", gpr_rd, 7);
    check("lb_di", gpr_di, 32'hFFFF_FF80);
    check("lb_busy", busy, 0);
    check("lb_ready", in_ready, 1);
    check("lb_pend", pend_bad, 0);
    do_load(5'd8, 3'b100, 2'd3, 4, 32'h80FF_FFFF, nbusy);
    check("lbu_di", gpr_di, 32'h0000_0080);
    check("lbu_we", gpr_we, 1);
    do_load(5'd8, 3'b001, 2'd2, 2, 32'hBEEF_1234, nbusy);
    check("lh_di", gpr_di, 32'hFFFF_BEEF);
    do_load(5'd8, 3'b101, 2'd0, 1, 32'hBEEF_9234, nbusy);
    check("lhu_di", gpr_di, 32'h0000_9234);
    check("lhu_busy_n", nbusy, 1);

    // LW to rd=9: pending during WAIT, bypass in write cycle
    do_load(5'd9, 3'b010, 2'd0, 3, 32'hCAFE_F00D, nbusy);
    check("lw_di", gpr_di, 32'hCAFE_F00D);
    check("lw_pend", pend_bad, 0);
    check("lw_fwd_v", fwd_valid, FwdEn ? 1 : 0);
    check("lw_fwd_rd", fwd_rd, FwdEn ? 9 : 0);

    // Misaligned LH: error, no write
    do_load(5'd10, 3'b001, 2'd1, 2, 32'h1111_2222, nbusy);
    check("lhmis_err", load_err, 1);
    check("lhmis_we", gpr_we, 0);
    check("lhmis_di", gpr_di, 32'hCAFE_F00D);
    check("lhmis_ready", in_ready, 1);
    tick();
    check("lhmis_err_pulse", load_err, 0);
    do_load(5'd10, 3'b110, 2'd0, 1, 32'h1111_2222, nbusy);
    check("illegal_err", load_err, 1);
    check("illegal_we", gpr_we, 0);
    do_load(5'd10, 3'b010, 2'd2, 1, 32'h1111_2222, nbusy);
    check("lwmis_err", load_err, 1);

    // Response in the last timeout cycle is a normal completion
    do_load(5'd11, 3'b010, 2'd0, 15, 32'h0BAD_CAFE, nbusy);
    check("edge_we", gpr_we, 1);
    check("edge_err", load_err, 0);
    check("edge_di", gpr_di, 32'h0BAD_CAFE);

    // Timeout: no response at all
    in_valid = 1'b1; in_sel = 2'b01; in_rd = 5'd12; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0; in_sel = 2'b11;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      tick();
    end
    check("to_busy_n", nbusy, 15);
    check("to_err", load_err, 1);
    check("to_we", gpr_we, 0);
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("late_we", gpr_we, 0);
    check("late_err", load_err, 0);
    check("late_di", gpr_di, 32'h0BAD_CAFE);

    // rd=0 and no-write selector
    in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd0; in_alu = 32'h0000_AAAA;
    tick();
    check("rd0_we", gpr_we, 0);
    check("rd0_di", gpr_di, 32'h0000_AAAA);
    in_sel = 2'b11; in_rd = 5'd3; in_alu = 32'h0000_BBBB;
    tick();
    in_valid = 1'b0;
    check("nowr_we", gpr_we, 0);
    check("nowr_di", gpr_di, 32'h0000_AAAA);
    check("nowr_rd", gpr_rd, 0);

    // Async reset mid-WAIT
    in_valid = 1'b1; in_sel = 2'b01; in_rd = 5'd13; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0; in_sel = 2'b11;
    tick();
    check("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    check("arst_di", gpr_di, 0);
    check("arst_pend", pend_valid, 0);
    #1 rst_n = 1'b1;
    tick();
    check("arst_err", load_err, 0);
    check("arst_we", gpr_we, 0);
    tick();
    check("arst_err2", load_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
